uart_tx_fifo_param: RTL

Next-generation UART transmitter core. It replaces the fixed-width serializer/parity/FSM/mux datapath with one parametrised block. New capabilities: a per-bit baud prescaler, selectable 1 or 2 stop bits, and an input FIFO so frames are sent back-to-back without gaps. It sits between the host-side parallel data source and the TX_out line.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_sync_fifo.sv | 55 +++++
 rtl/uart_tx_fifo_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// UART_TX_BREAK_EN adds the BREAK state.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
`ifdef UART_TX_BREAK_EN
        ,
        BREAK  = 3'd6
`endif
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module uart_tx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// FIFO-fed UART transmitter with per-bit prescaler, optional parity and 1/2 stop bits.
// Defining UART_TX_BREAK_EN adds the Break_req input and BREAK state.
module uart_tx_fifo_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Data_valid,
    input  logic [DATA_W-1:0]             P_data,
    output logic                          Ready,
    input  logic                          Par_en,
    input  logic                          Par_type,
    input  logic                          Stop2,
    input  logic [PRESCALE_W-1:0]         Prescale,
`ifdef UART_TX_BREAK_EN
    input  logic                          Break_req,
`endif
    output logic                          TX_out,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_count
);
    import uart_tx_pkg::*;

    localparam int unsigned       BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_e             r_state, w_state_next;
    logic [DATA_W-1:0]     r_shift, w_shift_next;
    logic [BIT_W-1:0]      r_bit, w_bit_next;
    logic [PRESCALE_W-1:0] r_timer, w_timer_next;
    logic [PRESCALE_W-1:0] r_prescale, w_prescale_next;
    logic                  r_par, w_par_next;
    logic                  r_par_en, w_par_en_next;
    logic                  r_stop2, w_stop2_next;
    logic                  r_tx, w_tx_next;
    logic                  w_pop, w_start, w_frame_end, w_bit_done;
    logic                  w_fifo_full, w_fifo_empty, w_par_calc;
    logic [DATA_W-1:0]     w_rdata;

    uart_tx_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (Data_valid),
        .i_wdata (P_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (Fifo_count)
    );

    assign Ready      = !w_fifo_full;
    assign Busy       = (r_state != IDLE) || (Fifo_count != '0);
    assign TX_out     = r_tx;
    assign w_bit_done = (r_timer == r_prescale);
    assign w_par_calc = (Par_type == PAR_EVEN) ? ^w_rdata : ~^w_rdata;

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_next      = r_bit;
        w_timer_next    = w_bit_done ? '0 : r_timer + 1'b1;
        w_prescale_next = r_prescale;
        w_par_next      = r_par;
        w_par_en_next   = r_par_en;
        w_stop2_next    = r_stop2;
        w_pop           = 1'b0;
        w_start         = 1'b0;
        w_frame_end     = 1'b0;
        w_tx_next       = IDLE_LINE;

        case (r_state)
            IDLE: begin
                w_timer_next = '0;
`ifdef UART_TX_BREAK_EN
                if (Break_req)          w_state_next = BREAK;
                else if (!w_fifo_empty) w_start = 1'b1;
`else
                if (!w_fifo_empty) w_start = 1'b1;
`endif
            end
            START: if (w_bit_done) begin
                w_state_next = DATA;
                w_bit_next   = '0;
            end
            DATA: if (w_bit_done) begin
                if (r_bit == LAST_BIT) begin
                    w_state_next = r_par_en ? PARITY : STOP1;
                end else begin
                    w_bit_next   = r_bit + 1'b1;
                    w_shift_next = r_shift >> 1;
                end
            end
            PARITY: if (w_bit_done) w_state_next = STOP1;
            STOP1: if (w_bit_done) begin
                if (r_stop2) w_state_next = STOP2;
                else         w_frame_end  = 1'b1;
            end
            STOP2: if (w_bit_done) w_frame_end = 1'b1;
`ifdef UART_TX_BREAK_EN
            // Releasing a break costs one stop-bit time; STOP2 always exits after one bit.
            BREAK: begin
                w_timer_next = '0;
                if (!Break_req) w_state_next = STOP2;
            end
`endif
            default: w_state_next = IDLE;
        endcase

        if (w_frame_end) begin
            w_state_next = IDLE;
`ifdef UART_TX_BREAK_EN
            if (Break_req)          w_state_next = BREAK;
            else if (!w_fifo_empty) w_start = 1'b1;
`else
            if (!w_fifo_empty) w_start = 1'b1;
`endif
        end

        if (w_start) begin
            w_pop           = 1'b1;
            w_state_next    = START;
            w_timer_next    = '0;
            w_shift_next    = w_rdata;
            w_par_next      = w_par_calc;
            w_par_en_next   = Par_en;
            w_stop2_next    = Stop2;
            w_prescale_next = Prescale;
        end

        // Line is registered from the next state so the start bit appears one edge after the pop.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_par_next;
`ifdef UART_TX_BREAK_EN
            BREAK:   w_tx_next = 1'b0;
`endif
            default: w_tx_next = IDLE_LINE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit      <= '0;
            r_timer    <= '0;
            r_prescale <= '0;
            r_par      <= 1'b0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx       <= IDLE_LINE;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit      <= w_bit_next;
            r_timer    <= w_timer_next;
            r_prescale <= w_prescale_next;
            r_par      <= w_par_next;
            r_par_en   <= w_par_en_next;
            r_stop2    <= w_stop2_next;
            r_tx       <= w_tx_next;
        end
    end

endmodule
